dmem_responder: RTL and testbench

- Data-memory slave at the far end of the MEM-stage handshake: the pipeline issues `mem_rw`/`addr`/`wdata` and this block answers with `dready_n` (read not ready) and `dbusy` (write in progress).
- The pipeline stalls all stages while `(dready_n && mem_rw[1]) || (dbusy && mem_rw[0])`.
- Contains a word-addressed RAM with RV32 byte/half/word access and programmable read/write latency.
- Stands in for the D-cache in simulation and FPGA builds.

---
 rtl/dmem_responder.sv | 260 ++++++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM behind the MEM-stage dready_n/dbusy handshake.
// Define DMEM_STORE_FWD_EN to add a one-entry background store buffer.
module dmem_responder #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned WR_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mem_rw,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic        dready_n,
    output logic        dbusy,
    output logic        misalign_err
);
    localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        WR_WAIT = 3'd2,
        RD_DONE = 3'd3,
        WR_DONE = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [31:0]      mem [DEPTH];

    logic [IDX_W-1:0] word_idx;
    logic [1:0]       lane;
    logic             access_ok;
    logic [3:0]       st_be;
    logic [31:0]      st_data;
    logic [31:0]      ram_word;
    logic [31:0]      merged_word;
    logic [31:0]      lane_word;
    logic [31:0]      load_val;
    logic             store_fast;
    logic             buf_busy;
    logic             ram_we;
    logic [IDX_W-1:0] ram_idx;
    logic [3:0]       ram_be;
    logic [31:0]      ram_data;
    logic             unused_addr_hi;

    // Upper address bits alias onto the RAM
    assign word_idx       = addr[IDX_W+1:2];
    assign lane           = addr[1:0];
    assign unused_addr_hi = ^addr[31:IDX_W+2];
    assign ram_word       = mem[word_idx];

    // Size/alignment legality; stores have no unsigned forms, load+store together is illegal
    always_comb begin
        access_ok = 1'b0;
        case (funct3)
            3'b000, 3'b100: access_ok = 1'b1;
            3'b001, 3'b101: access_ok = ~addr[0];
            3'b010:         access_ok = (addr[1:0] == 2'b00);
            default:        access_ok = 1'b0;
        endcase
        if ((mem_rw[0] && funct3[2]) || (&mem_rw)) begin
            access_ok = 1'b0;
        end
    end

    // Store lane steering
    always_comb begin
        st_be   = 4'b1111;
        st_data = wdata;
        case (funct3[1:0])
            2'b00: begin
                st_be   = 4'b0001 << lane;
                st_data = {4{wdata[7:0]}};
            end
            2'b01: begin
                st_be   = 4'b0011 << lane;
                st_data = {2{wdata[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = wdata;
            end
        endcase
    end

    // Load lane select and extension
    assign lane_word = merged_word >> {lane, 3'b000};
    always_comb begin
        case (funct3)
            3'b000:  load_val = {{24{lane_word[7]}}, lane_word[7:0]};
            3'b001:  load_val = {{16{lane_word[15]}}, lane_word[15:0]};
            3'b100:  load_val = {24'd0, lane_word[7:0]};
            3'b101:  load_val = {16'd0, lane_word[15:0]};
            default: load_val = merged_word;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // The IDLE cycle is the first stall cycle, so WAIT lasts LAT-1 cycles
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = 1'b0;
        dready_n = 1'b0;
        dbusy    = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_rw[1]) begin
                    dready_n = 1'b1;
                    if (RD_LAT <= 1) begin
                        state_d = RD_DONE;
                        rdata_d = access_ok ? load_val : 32'd0;
                        err_d   = ~access_ok;
                    end else begin
                        state_d = RD_WAIT;
                        cnt_d   = CNT_W'(RD_LAT - 1);
                    end
                end else if (mem_rw[0]) begin
                    if (store_fast) begin
                        dbusy = buf_busy;
                    end else begin
                        dbusy = 1'b1;
                        if (WR_LAT <= 1) begin
                            state_d = WR_DONE;
                            err_d   = ~access_ok;
                        end else begin
                            state_d = WR_WAIT;
                            cnt_d   = CNT_W'(WR_LAT - 1);
                        end
                    end
                end
            end
            RD_WAIT: begin
                dready_n = 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RD_DONE;
                    cnt_d   = '0;
                    rdata_d = access_ok ? load_val : 32'd0;
                    err_d   = ~access_ok;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR_WAIT: begin
                dbusy = 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = WR_DONE;
                    cnt_d   = '0;
                    err_d   = ~access_ok;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RD_DONE, WR_DONE: state_d = IDLE;
            default:          state_d = IDLE;
        endcase
    end

`ifdef DMEM_STORE_FWD_EN
    logic             buf_valid_q;
    logic [CNT_W-1:0] buf_cnt_q;
    logic [IDX_W-1:0] buf_idx_q;
    logic [3:0]       buf_be_q;
    logic [31:0]      buf_data_q;
    logic             buf_capture;
    logic             buf_drain;
    logic             buf_hit;

    // Faulting stores take the blocking path so misalign_err gets its DONE cycle
    assign store_fast  = access_ok;
    assign buf_busy    = buf_valid_q;
    assign buf_capture = (state_q == IDLE) && (mem_rw == 2'b01) && access_ok && !buf_valid_q;
    assign buf_drain   = buf_valid_q && (buf_cnt_q == '0);
    assign buf_hit     = buf_valid_q && (buf_idx_q == word_idx);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid_q <= 1'b0;
            buf_cnt_q   <= '0;
            buf_idx_q   <= '0;
            buf_be_q    <= '0;
            buf_data_q  <= '0;
        end else if (buf_capture) begin
            buf_valid_q <= 1'b1;
            buf_cnt_q   <= CNT_W'(WR_LAT - 1);
            buf_idx_q   <= word_idx;
            buf_be_q    <= st_be;
            buf_data_q  <= st_data;
        end else if (buf_valid_q) begin
            if (buf_cnt_q == '0) begin
                buf_valid_q <= 1'b0;
            end else begin
                buf_cnt_q <= buf_cnt_q - CNT_W'(1);
            end
        end
    end

    // Buffered bytes override RAM bytes for loads to the same word
    always_comb begin
        merged_word = ram_word;
        for (int i = 0; i < 4; i++) begin
            if (buf_hit && buf_be_q[i]) begin
                merged_word[8*i +: 8] = buf_data_q[8*i +: 8];
            end
        end
    end

    assign ram_we   = buf_drain;
    assign ram_idx  = buf_idx_q;
    assign ram_be   = buf_be_q;
    assign ram_data = buf_data_q;
`else
    assign store_fast  = 1'b0;
    assign buf_busy    = 1'b0;
    assign merged_word = ram_word;

    // Commit on the edge entering WR_DONE; never while reset is asserted
    assign ram_we   = rst && (state_d == WR_DONE) && access_ok;
    assign ram_idx  = word_idx;
    assign ram_be   = st_be;
    assign ram_data = st_data;
`endif

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_be[i]) begin
                    mem[ram_idx][8*i +: 8] <= ram_data[8*i +: 8];
                end
            end
        end
    end

    assign rdata        = rdata_q;
    assign misalign_err = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random traffic
// against a byte-level memory model with a cycle-based store-buffer timing model.
`timescale 1ns/1ps
module tb_dmem_responder;
    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned RD_LAT = 2;
`ifdef DMEM_STORE_FWD_EN
    localparam int unsigned WR_LAT = 4;
    localparam bit          FWD    = 1'b1;
`else
    localparam int unsigned WR_LAT = 1;
    localparam bit          FWD    = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mem_rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic [31:0] rdata;
    logic        dready_n;
    logic        dbusy;
    logic        misalign_err;

    dmem_responder #(.DEPTH(DEPTH), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
        .clk(clk), .rst(rst), .mem_rw(mem_rw), .addr(addr), .wdata(wdata),
        .funct3(funct3), .rdata(rdata), .dready_n(dready_n), .dbusy(dbusy),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] ref_mem [int];
    logic [31:0] last_rd    = 32'd0;
    int          busy_until = -100;

    // Observed and expected results of the latest access
    int          st;
    logic [31:0] rd;
    logic        ed;
    logic        ee;
    int          es;
    logic [31:0] erd;
    logic        eerr;

    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'd2) return 4;
        if (f3[1:0] == 2'd1) return 2;
        return 1;
    endfunction

    function automatic bit legal(input logic [1:0] rw, input logic [31:0] a, input logic [2:0] f3);
        if (rw == 2'b11) return 1'b0;
        if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        if (rw == 2'b01 && f3 > 3'd2) return 1'b0;
        return (a % 32'(size_of(f3))) == 32'd0;
    endfunction

    task automatic model_access(input logic [1:0] rw, input logic [31:0] a, input logic [31:0] wd,
                                input logic [2:0] f3, input int t0);
        bit          ok;
        int          lane;
        int          widx;
        int          sz;
        logic [31:0] w;
        logic [31:0] v;
        ok   = legal(rw, a, f3);
        lane = int'(a % 32'd4);
        widx = int'((a / 32'd4) % DEPTH);
        sz   = size_of(f3);
        w    = ref_mem.exists(widx) ? ref_mem[widx] : 32'd0;
        eerr = !ok;
        if (rw[1]) begin
            es = RD_LAT;
            v  = 32'd0;
            if (ok) begin
                v = w >> (8 * lane);
                case (f3)
                    3'd0: begin v = v % 256;   if (v >= 128)   v = v - 32'd256;   end
                    3'd1: begin v = v % 65536; if (v >= 32768) v = v - 32'd65536; end
                    3'd4: v = v % 256;
                    3'd5: v = v % 65536;
                    default: v = w;
                endcase
            end
            erd     = v;
            last_rd = v;
        end else begin
            erd = last_rd;
            if (FWD && ok) begin
                es = busy_until - t0 + 1;
                if (es < 0) es = 0;
                busy_until = t0 + es + int'(WR_LAT);
            end else begin
                es = WR_LAT;
            end
            if (ok) begin
                for (int k = 0; k < sz; k++) w[8*(lane+k) +: 8] = wd[8*k +: 8];
                ref_mem[widx] = w;
            end
        end
    endtask

    // Present one access, count stall cycles, sample the DONE cycle; called at posedge+1
    task automatic access(input logic [1:0] rw, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] f3, output int t0);
        mem_rw = rw; addr = a; wdata = wd; funct3 = f3;
        t0 = cyc; st = 0; ee = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if ((dready_n && mem_rw[1]) || (dbusy && mem_rw[0])) begin
                st++;
                if (misalign_err) ee = 1'b1;
                @(posedge clk); #1;
            end else begin
                break;
            end
        end
        rd = rdata;
        ed = misalign_err;
        @(posedge clk); #1;
        mem_rw = 2'b00;
    endtask

    task automatic run(input logic [1:0] rw, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3);
        int t0;
        access(rw, a, wd, f3, t0);
        model_access(rw, a, wd, f3, t0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        rst = 1'b0; mem_rw = 2'b00; addr = '0; wdata = '0; funct3 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (dready_n !== 1'b0) begin n_fail++; $display("FAIL reset_dready_n: got %0b expected 0", dready_n); end
        n_checks++; if (dbusy !== 1'b0) begin n_fail++; $display("FAIL reset_dbusy: got %0b expected 0", dbusy); end
        n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b expected 0", misalign_err); end
        @(posedge clk); #1 rst = 1'b1;
        idle(1);
    endtask

    task automatic test_word_round_trip;
        run(2'b01, 32'h10, 32'hDEADBEEF, 3'b010);
        n_checks++; if (st !== es) begin n_fail++; $display("FAIL rt_sw_stall: got %0d expected %0d", st, es); end
        run(2'b10, 32'h10, 32'h0, 3'b010);
        n_checks++; if (st !== RD_LAT) begin n_fail++; $display("FAIL rt_lw_stall: got %0d expected %0d", st, RD_LAT); end
        n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rt_lw_data: got %h expected deadbeef", rd); end
    endtask

    task automatic test_extension;
        logic [31:0] ea [4];
        logic [31:0] aa [4];
        logic [2:0]  fa [4];
        ea = '{32'hFFFFFF80, 32'h00000080, 32'h00007F01, 32'h000080FF};
        aa = '{32'h23, 32'h23, 32'h20, 32'h22};
        fa = '{3'b000, 3'b100, 3'b001, 3'b101};
        run(2'b01, 32'h20, 32'h80FF7F01, 3'b010);
        for (int i = 0; i < 4; i++) begin
            run(2'b10, aa[i], 32'h0, fa[i]);
            n_checks++; if (rd !== ea[i]) begin n_fail++; $display("FAIL ext_load%0d: got %h expected %h", i, rd, ea[i]); end
            n_checks++; if (ed !== 1'b0) begin n_fail++; $display("FAIL ext_err%0d: got %0b expected 0", i, ed); end
        end
    endtask

    task automatic test_partial_store;
        run(2'b01, 32'h30, 32'h11223344, 3'b010);
        run(2'b01, 32'h31, 32'h000000AA, 3'b000);
        n_checks++; if (st !== es) begin n_fail++; $display("FAIL sb_stall: got %0d expected %0d", st, es); end
        run(2'b10, 32'h30, 32'h0, 3'b010);
        n_checks++; if (rd !== 32'h1122AA44) begin n_fail++; $display("FAIL partial_data: got %h expected 1122aa44", rd); end
    endtask

    task automatic test_misalign;
        logic [1:0]  rwa [5];
        logic [31:0] aa  [5];
        logic [2:0]  fa  [5];
        rwa = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b01};
        aa  = '{32'h32, 32'h31, 32'h30, 32'h30, 32'h30};
        fa  = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100};
        for (int i = 0; i < 5; i++) begin
            run(rwa[i], aa[i], 32'hCAFEF00D, fa[i]);
            n_checks++; if (st !== es) begin n_fail++; $display("FAIL mis_stall%0d: got %0d expected %0d", i, st, es); end
            n_checks++; if (ed !== 1'b1) begin n_fail++; $display("FAIL mis_err%0d: got %0b expected 1", i, ed); end
            n_checks++; if (ee !== 1'b0) begin n_fail++; $display("FAIL mis_err_early%0d: got %0b expected 0", i, ee); end
            n_checks++; if (rd !== erd) begin n_fail++; $display("FAIL mis_rdata%0d: got %h expected %h", i, rd, erd); end
        end
        @(negedge clk);
        n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL mis_pulse_len: got %0b expected 0", misalign_err); end
        idle(1);
        run(2'b10, 32'h30, 32'h0, 3'b010);
        n_checks++; if (rd !== 32'h1122AA44) begin n_fail++; $display("FAIL mis_ram_kept: got %h expected 1122aa44", rd); end
    endtask

    task automatic test_back_to_back;
        run(2'b01, 32'h50, 32'h0BADCAFE, 3'b010);
        n_checks++; if (st !== es) begin n_fail++; $display("FAIL b2b_sw_stall: got %0d expected %0d", st, es); end
        run(2'b10, 32'h50, 32'h0, 3'b010);
        n_checks++; if (st !== RD_LAT) begin n_fail++; $display("FAIL b2b_lw_stall: got %0d expected %0d", st, RD_LAT); end
        n_checks++; if (rd !== 32'h0BADCAFE) begin n_fail++; $display("FAIL b2b_lw_data: got %h expected 0badcafe", rd); end
    endtask

`ifdef DMEM_STORE_FWD_EN
    task automatic test_store_fwd;
        idle(8);
        run(2'b01, 32'h40, 32'h55AA55AA, 3'b010);
        n_checks++; if (st !== 0) begin n_fail++; $display("FAIL fwd_sw_stall: got %0d expected 0", st); end
        run(2'b10, 32'h40, 32'h0, 3'b010);
        n_checks++; if (rd !== 32'h55AA55AA) begin n_fail++; $display("FAIL fwd_lw_data: got %h expected 55aa55aa", rd); end
        idle(8);
        run(2'b01, 32'h44, 32'h01010101, 3'b010);
        n_checks++; if (st !== 0) begin n_fail++; $display("FAIL fwd_first_stall: got %0d expected 0", st); end
        run(2'b01, 32'h48, 32'h02020202, 3'b010);
        n_checks++; if (st !== WR_LAT) begin n_fail++; $display("FAIL fwd_second_stall: got %0d expected %0d", st, WR_LAT); end
        run(2'b10, 32'h44, 32'h0, 3'b010);
        n_checks++; if (rd !== 32'h01010101) begin n_fail++; $display("FAIL fwd_drained_data: got %h expected 01010101", rd); end
    endtask
`endif

    task automatic test_reset_mid_read;
        idle(8);
        run(2'b10, 32'h10, 32'h0, 3'b010);
        mem_rw = 2'b10; addr = 32'h10; funct3 = 3'b010;
        @(posedge clk); #1;
        rst = 1'b0; mem_rw = 2'b00;
        @(negedge clk);
        n_checks++; if (dready_n !== 1'b0) begin n_fail++; $display("FAIL midrst_dready_n: got %0b expected 0", dready_n); end
        n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL midrst_rdata: got %h expected 0", rdata); end
        @(posedge clk); #1 rst = 1'b1;
        last_rd = 32'd0; busy_until = -100;
        idle(1);
        run(2'b10, 32'h10, 32'h0, 3'b010);
        n_checks++; if (st !== RD_LAT) begin n_fail++; $display("FAIL midrst_after_stall: got %0d expected %0d", st, RD_LAT); end
        n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL midrst_after_data: got %h expected deadbeef", rd); end
    endtask

    task automatic test_random;
        logic [1:0]  rw;
        logic [31:0] a;
        logic [2:0]  f3;
        int          r;
        for (int k = 0; k < 8; k++) begin
            run(2'b01, 32'h100 + 32'(4 * k), $urandom, 3'b010);
            n_checks++; if (st !== es) begin n_fail++; $display("FAIL rnd_init_stall%0d: got %0d expected %0d", k, st, es); end
        end
        for (int n = 0; n < 150; n++) begin
            r  = int'($urandom_range(0, 9));
            rw = (r < 5) ? 2'b10 : (r < 9) ? 2'b01 : 2'b11;
            a  = 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3))
               + (32'($urandom_range(0, 7)) << 12);
            if ($urandom_range(0, 9) < 7) begin
                r  = int'($urandom_range(0, 4));
                f3 = (r == 3) ? 3'd4 : (r == 4) ? 3'd5 : 3'(r);
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            run(rw, a, $urandom, f3);
            n_checks++; if (st !== es) begin n_fail++; $display("FAIL rnd_stall%0d: rw=%b a=%h f3=%0d got %0d expected %0d", n, rw, a, f3, st, es); end
            n_checks++; if (rd !== erd) begin n_fail++; $display("FAIL rnd_rdata%0d: rw=%b a=%h f3=%0d got %h expected %h", n, rw, a, f3, rd, erd); end
            n_checks++; if (ed !== eerr) begin n_fail++; $display("FAIL rnd_err%0d: rw=%b a=%h f3=%0d got %0b expected %0b", n, rw, a, f3, ed, eerr); end
            n_checks++; if (ee !== 1'b0) begin n_fail++; $display("FAIL rnd_err_early%0d: got %0b expected 0", n, ee); end
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(0, 5)));
        end
    endtask

    initial begin
        test_reset();
        test_word_round_trip();
        test_extension();
        test_partial_store();
        test_misalign();
        test_back_to_back();
`ifdef DMEM_STORE_FWD_EN
        test_store_fwd();
`endif
        test_reset_mid_read();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
